// File: rtl/spi_xfer_fifo_if.sv
// spi_xfer_fifo_if
// Bundles the CPU-side FIFO access, the sticky status flags and the SPI
// engine handshake of spi_xfer_fifo. The slave modport is the FIFO block
// itself; the master modport is its environment (register logic + engine).
interface spi_xfer_fifo_if #(
  parameter int D_WIDTH = 8,
  parameter int AW      = 3
);
  logic               tx_wr_en;
  logic [D_WIDTH-1:0] tx_wdata;
  logic               tx_full;
  logic [AW:0]        tx_level;
  logic               rx_rd_en;
  logic [D_WIDTH-1:0] rx_rdata;
  logic               rx_empty;
  logic [AW:0]        rx_level;
  logic               clr_flags;
  logic               tx_ovf;
  logic               rx_ovf;
  logic               xfer_err;
  logic               idle;
  logic               core_enable;
  logic [D_WIDTH-1:0] core_tx_data;
  logic               core_busy;
  logic [D_WIDTH-1:0] core_rx_data;

  modport slave (
    input  tx_wr_en, tx_wdata, rx_rd_en, clr_flags, core_busy, core_rx_data,
    output tx_full, tx_level, rx_rdata, rx_empty, rx_level,
           tx_ovf, rx_ovf, xfer_err, idle, core_enable, core_tx_data
  );

  modport master (
    output tx_wr_en, tx_wdata, rx_rd_en, clr_flags, core_busy, core_rx_data,
    input  tx_full, tx_level, rx_rdata, rx_empty, rx_level,
           tx_ovf, rx_ovf, xfer_err, idle, core_enable, core_tx_data
  );
endinterface

// File: rtl/spi_xfer_fifo.sv
// spi_xfer_fifo
// Byte-stream front end for the SPI shift engine: a TX FIFO filled by the
// CPU, an FSM that runs one engine transfer per queued byte (start pulse,
// wait for busy to rise, wait for busy to fall, capture), and an RX FIFO
// drained by the CPU. Overflows are reported as sticky flags.
// Optional feature: define SPI_XFER_TIMEOUT_EN to abandon a transfer whose
// engine never raises busy, reporting it on xfer_err. Without it xfer_err
// is tied low and WAIT_BUSY waits indefinitely.
module spi_xfer_fifo #(
  parameter int D_WIDTH = 8,
  parameter int AW      = 3
) (
  input logic            clk,
  input logic            reset,
  spi_xfer_fifo_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CAPTURE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [D_WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]      tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]        tx_cnt;
  logic [D_WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]      rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]        rx_cnt;
  logic [D_WIDTH-1:0] rx_out;
  logic               core_en;
  logic [D_WIDTH-1:0] core_data;
  logic               tx_ovf_flag, rx_ovf_flag;

  logic tx_is_full, tx_is_empty, rx_is_full, rx_is_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;

`ifdef SPI_XFER_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       timeout_hit;
  logic       xfer_err_flag;
`endif

  assign tx_is_full  = (tx_cnt == LVL_FULL);
  assign tx_is_empty = (tx_cnt == {(AW+1){1'b0}});
  assign rx_is_full  = (rx_cnt == LVL_FULL);
  assign rx_is_empty = (rx_cnt == {(AW+1){1'b0}});

  // Full/empty are the pre-edge values, so a push into a full TX FIFO is
  // dropped even when the FSM pops in the same cycle (same for RX).
  assign tx_push = bus.tx_wr_en && !tx_is_full;
  assign tx_pop  = (state == S_IDLE) && !tx_is_empty;
  assign rx_push = (state == S_CAPTURE) && !rx_is_full;
  assign rx_pop  = bus.rx_rd_en && !rx_is_empty;

  // Next-state decode of the per-byte transfer sequencer
  always_comb begin
    state_nxt = state;
`ifdef SPI_XFER_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (tx_pop) state_nxt = S_START;
        else        state_nxt = S_IDLE;
      end
      S_START: state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.core_busy) state_nxt = S_WAIT_DONE;
`ifdef SPI_XFER_TIMEOUT_EN
        // wait_cnt is 0 in the first WAIT_BUSY cycle, so 14 here means the
        // counter would reach 15 at the end of the 15th waiting cycle.
        else if (wait_cnt == 4'd14) begin
          state_nxt   = S_IDLE;
          timeout_hit = 1'b1;
        end
`endif
        else state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_DONE: begin
        if (bus.core_busy) state_nxt = S_WAIT_DONE;
        else               state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register, registered start pulse and the byte held for the engine
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      core_en   <= 1'b0;
      core_data <= {D_WIDTH{1'b0}};
    end else begin
      state   <= state_nxt;
      core_en <= (state_nxt == S_START);
      if (tx_pop) core_data <= tx_mem[tx_rd_ptr];
      else        core_data <= core_data;
    end
  end

  // TX storage: write the pushed byte at the write pointer
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.tx_wdata;
  end

  // TX pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= {AW{1'b0}};
      tx_rd_ptr <= {AW{1'b0}};
      tx_cnt    <= {(AW+1){1'b0}};
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + LVL_ONE;
        2'b01:   tx_cnt <= tx_cnt - LVL_ONE;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // RX storage: capture the engine byte at the write pointer
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.core_rx_data;
  end

  // RX pointers, occupancy and the registered read-data port
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr <= {AW{1'b0}};
      rx_rd_ptr <= {AW{1'b0}};
      rx_cnt    <= {(AW+1){1'b0}};
      rx_out    <= {D_WIDTH{1'b0}};
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
        rx_out    <= rx_mem[rx_rd_ptr];
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + LVL_ONE;
        2'b01:   rx_cnt <= rx_cnt - LVL_ONE;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Sticky overflow flags; a clear wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (reset || bus.clr_flags) begin
      tx_ovf_flag <= 1'b0;
      rx_ovf_flag <= 1'b0;
    end else begin
      if (bus.tx_wr_en && tx_is_full)          tx_ovf_flag <= 1'b1;
      if ((state == S_CAPTURE) && rx_is_full)  rx_ovf_flag <= 1'b1;
    end
  end

`ifdef SPI_XFER_TIMEOUT_EN
  // Count cycles spent waiting for the engine to acknowledge a start
  always_ff @(posedge clk) begin
    if (reset)                      wait_cnt <= 4'd0;
    else if (state != S_WAIT_BUSY)  wait_cnt <= 4'd0;
    else                            wait_cnt <= wait_cnt + 4'd1;
  end

  // Sticky start-timeout flag; a clear wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (reset || bus.clr_flags) xfer_err_flag <= 1'b0;
    else if (timeout_hit)       xfer_err_flag <= 1'b1;
    else                        xfer_err_flag <= xfer_err_flag;
  end

  assign bus.xfer_err = xfer_err_flag;
`else
  assign bus.xfer_err = 1'b0;
`endif

  assign bus.tx_full      = tx_is_full;
  assign bus.tx_level     = tx_cnt;
  assign bus.rx_empty     = rx_is_empty;
  assign bus.rx_level     = rx_cnt;
  assign bus.rx_rdata     = rx_out;
  assign bus.tx_ovf       = tx_ovf_flag;
  assign bus.rx_ovf       = rx_ovf_flag;
  assign bus.idle         = (state == S_IDLE) && tx_is_empty;
  assign bus.core_enable  = core_en;
  assign bus.core_tx_data = core_data;
endmodule

// File: tb/tb_spi_xfer_fifo.sv
// tb_spi_xfer_fifo
// Directed bench for spi_xfer_fifo. Bytes handed to the engine are checked
// against a TX scoreboard queue by an enable monitor; bytes popped from RX
// are checked against an RX scoreboard queue by a read monitor. A small
// engine model answers start pulses: busy rises 2 cycles after the pulse,
// stays high 10 cycles (or while eng_stall is set), then falls with the
// next byte from eng_rx on core_rx_data.
module tb_spi_xfer_fifo;
  localparam int D_WIDTH = 8;
  localparam int AW      = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_fifo_if #(.D_WIDTH(D_WIDTH), .AW(AW)) bus ();

  spi_xfer_fifo #(.D_WIDTH(D_WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int en_count = 0;
  int fall_cyc = 0;
  bit gap_chk  = 1'b0;
  bit eng_stall = 1'b0;
  bit eng_dead  = 1'b0;
  bit prev_en   = 1'b0;
  bit rd_seen   = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] eng_rx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.tx_wr_en = 1'b1;
    bus.tx_wdata = b;
    tick();
    bus.tx_wr_en = 1'b0;
  endtask

  task automatic rx_read();
    bus.rx_rd_en = 1'b1;
    tick();
    bus.rx_rd_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (bus.idle !== 1'b1 && k < budget) begin tick(); k++; end
    if (bus.idle !== 1'b1)
      fail_evt(name, $sformatf("idle=%b after %0d cycles, required 1", bus.idle, budget));
  endtask

  task automatic wait_busy(input logic lvl, input string name, input int budget);
    int k = 0;
    while (bus.core_busy !== lvl && k < budget) begin tick(); k++; end
    if (bus.core_busy !== lvl)
      fail_evt(name, $sformatf("core_busy=%b after %0d cycles, required %b", bus.core_busy, budget, lvl));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: acts 2 time units after the edge so bench polls at #1 see
  // the previous value and the DUT sees the new one at the next edge.
  initial begin
    bus.core_busy    = 1'b0;
    bus.core_rx_data = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (bus.core_enable === 1'b1 && !eng_dead) begin
        repeat (2) begin @(posedge clk); #2; end
        bus.core_busy = 1'b1;
        for (int n = 0; (n < 10) || eng_stall; n++) begin @(posedge clk); #2; end
        bus.core_busy = 1'b0;
        if (eng_rx.size() > 0) bus.core_rx_data = eng_rx.pop_front();
        else                   bus.core_rx_data = 8'hEE;
        fall_cyc = cyc;
      end
    end
  end

  // TX monitor: every start pulse must carry the next expected byte
  always @(negedge clk) begin
    if (bus.core_enable === 1'b1) begin
      en_count <= en_count + 1;
      chk("en_pulse_width", {31'd0, prev_en}, 32'd0);
      if (exp_tx.size() > 0) chk("tx_byte", {24'd0, bus.core_tx_data}, {24'd0, exp_tx.pop_front()});
      else fail_evt("tx_unexpected", $sformatf("got transfer of %02h, required none", bus.core_tx_data));
      if (gap_chk) chk("tx_gap", cyc - fall_cyc, 32'd3);
    end
    prev_en <= (bus.core_enable === 1'b1);
  end

  // RX monitor: the cycle after each read strobe rx_rdata must match
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rx.size() > 0) chk("rx_byte", {24'd0, bus.rx_rdata}, {24'd0, exp_rx.pop_front()});
      else fail_evt("rx_unexpected", $sformatf("got read of %02h, required none", bus.rx_rdata));
    end
    rd_seen <= (bus.rx_rd_en === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    bus.tx_wr_en = 1'b0; bus.tx_wdata = 8'h00; bus.rx_rd_en = 1'b0; bus.clr_flags = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_tx_full", bus.tx_full, 1'b0);
    chk("rst_tx_level", bus.tx_level, 4'd0);
    chk("rst_rx_empty", bus.rx_empty, 1'b1);
    chk("rst_rx_level", bus.rx_level, 4'd0);
    chk("rst_idle", bus.idle, 1'b1);
    chk("rst_flags", {bus.tx_ovf, bus.rx_ovf, bus.xfer_err}, 3'b000);
    chk("rst_core_enable", bus.core_enable, 1'b0);
    chk("rst_core_tx_data", bus.core_tx_data, 8'h00);
    chk("rst_rx_rdata", bus.rx_rdata, 8'h00);

    // T1: single byte round trip
    eng_rx.push_back(8'h3C);
    exp_tx.push_back(8'hA5);
    e0 = en_count;
    push(8'hA5);
    wait_idle("t1_idle_timeout", 60);
    chk("t1_en_count", en_count - e0, 32'd1);
    chk("t1_core_tx_data", bus.core_tx_data, 8'hA5);
    chk("t1_rx_level", bus.rx_level, 4'd1);
    exp_rx.push_back(8'h3C);
    rx_read();
    chk("t1_rx_rdata", bus.rx_rdata, 8'h3C);
    chk("t1_rx_empty", bus.rx_empty, 1'b1);
    exp_rx.push_back(8'h3C);               // read while empty holds rx_rdata
    rx_read();
    tick();
    chk("t1_empty_read_level", bus.rx_level, 4'd0);
    chk("t1_empty_read_no_flag", bus.rx_ovf, 1'b0);

    // T2/T3: fill TX behind a stalled engine, overflow both FIFOs
    for (int i = 0; i < 9; i++) eng_rx.push_back(8'hC0 + 8'(i));
    eng_stall = 1'b1;
    exp_tx.push_back(8'hF0);
    push(8'hF0);
    wait_busy(1'b1, "t2_busy_timeout", 20);
    for (int i = 1; i <= 8; i++) begin
      exp_tx.push_back(8'(i));
      push(8'(i));
    end
    chk("t2_tx_full", bus.tx_full, 1'b1);
    chk("t2_tx_level", bus.tx_level, 4'd8);
    chk("t2_tx_ovf_pre", bus.tx_ovf, 1'b0);
    push(8'h09);
    chk("t2_tx_ovf", bus.tx_ovf, 1'b1);
    chk("t2_tx_level_after_ovf", bus.tx_level, 4'd8);
    gap_chk = 1'b1;
    eng_stall = 1'b0;
    wait_idle("t2_idle_timeout", 300);
    gap_chk = 1'b0;
    chk("t2_all_sent", exp_tx.size(), 32'd0);
    chk("t3_rx_level", bus.rx_level, 4'd8);
    chk("t3_rx_ovf", bus.rx_ovf, 1'b1);
    chk("t3_tx_ovf_sticky", bus.tx_ovf, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_rx.push_back(8'hC0 + 8'(i));
      rx_read();
    end
    tick();
    chk("t3_rx_empty", bus.rx_empty, 1'b1);
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    chk("t3_clr_flags", {bus.tx_ovf, bus.rx_ovf}, 2'b00);

    // T4: reset during WAIT_DONE with bytes queued
    eng_rx.push_back(8'h77);
    exp_tx.push_back(8'hA1);
    e0 = en_count;
    push(8'hA1); push(8'hA2); push(8'hA3);
    wait_busy(1'b1, "t4_busy_timeout", 20);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("t4_tx_level", bus.tx_level, 4'd0);
    chk("t4_rx_level", bus.rx_level, 4'd0);
    chk("t4_idle", bus.idle, 1'b1);
    chk("t4_core_tx_data", bus.core_tx_data, 8'h00);
    chk("t4_rx_rdata", bus.rx_rdata, 8'h00);
    repeat (20) tick();
    chk("t4_no_capture", bus.rx_level, 4'd0);
    chk("t4_en_count", en_count - e0, 32'd1);

    // T5: simultaneous push/pop on TX and read/capture on RX
    for (int i = 0; i < 6; i++) eng_rx.push_back(8'hD0 + 8'(i));
    eng_stall = 1'b1;
    exp_tx.push_back(8'h50);
    push(8'h50);
    wait_busy(1'b1, "t5_busy_timeout", 20);
    for (int i = 1; i <= 4; i++) begin
      exp_tx.push_back(8'h50 + 8'(i));
      push(8'h50 + 8'(i));
    end
    chk("t5_tx_level_pre", bus.tx_level, 4'd4);
    eng_stall = 1'b0;
    wait_busy(1'b0, "t5_fall_timeout", 20);   // now in CAPTURE
    tick();                                   // IDLE: FSM pops this cycle
    exp_tx.push_back(8'h55);
    push(8'h55);
    chk("t5_tx_level_same", bus.tx_level, 4'd4);
    chk("t5_rx_level_one", bus.rx_level, 4'd1);
    wait_busy(1'b1, "t5_b51_rise", 30);
    wait_busy(1'b0, "t5_b51_fall", 30);
    wait_busy(1'b1, "t5_b52_rise", 30);
    wait_busy(1'b0, "t5_b52_fall", 30);       // CAPTURE of the third byte
    chk("t5_rx_level_pre", bus.rx_level, 4'd2);
    exp_rx.push_back(8'hD0);
    rx_read();
    chk("t5_rx_level_same", bus.rx_level, 4'd2);
    wait_idle("t5_idle_timeout", 200);
    chk("t5_rx_level_end", bus.rx_level, 4'd5);
    for (int i = 1; i <= 5; i++) begin
      exp_rx.push_back(8'hD0 + 8'(i));
      rx_read();
    end
    tick();
    chk("t5_rx_empty", bus.rx_empty, 1'b1);

    // T6: engine never acknowledges the start pulse
    eng_dead = 1'b1;
    e0 = en_count;
`ifdef SPI_XFER_TIMEOUT_EN
    eng_rx.push_back(8'h99);
    exp_tx.push_back(8'h66);
    exp_tx.push_back(8'h67);
    push(8'h66);
    push(8'h67);
    begin
      int k = 0;
      while (bus.core_enable !== 1'b1 && k < 10) begin tick(); k++; end
    end
    chk("t6_start_seen", bus.core_enable, 1'b1);
    repeat (15) tick();
    chk("t6_xfer_err_pre", bus.xfer_err, 1'b0);
    tick();
    chk("t6_xfer_err", bus.xfer_err, 1'b1);
    eng_dead = 1'b0;
    tick();
    chk("t6_next_start", bus.core_enable, 1'b1);
    wait_idle("t6_idle_timeout", 40);
    chk("t6_rx_level", bus.rx_level, 4'd1);
    chk("t6_en_count", en_count - e0, 32'd2);
    exp_rx.push_back(8'h99);
    rx_read();
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    chk("t6_xfer_err_clr", bus.xfer_err, 1'b0);
`else
    exp_tx.push_back(8'h66);
    push(8'h66);
    repeat (30) tick();
    chk("t6_xfer_err", bus.xfer_err, 1'b0);
    chk("t6_not_idle", bus.idle, 1'b0);
    chk("t6_tx_level", bus.tx_level, 4'd0);
    chk("t6_en_count", en_count - e0, 32'd1);
    chk("t6_core_tx_data", bus.core_tx_data, 8'h66);
    bus.core_busy = 1'b1;
    tick(); tick();
    bus.core_rx_data = 8'h99;
    bus.core_busy = 1'b0;
    eng_dead = 1'b0;
    wait_idle("t6_idle_timeout", 20);
    chk("t6_rx_level", bus.rx_level, 4'd1);
    exp_rx.push_back(8'h99);
    rx_read();
`endif
    tick(); tick();
    chk("sb_tx_drained", exp_tx.size(), 32'd0);
    chk("sb_rx_drained", exp_rx.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
